// File: rtl/muldiv_if.sv
// Operand/result handshake bundle between the execute stage and the muldiv unit.
// op encoding: 0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW.
interface muldiv_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    modport master (
        output in_valid, op, in1, in2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, in1, in2, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete immediately.
module muldiv (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam logic [3:0] OP_MUL   = 4'd0;
    localparam logic [3:0] OP_MULW  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_REM   = 4'd4;
    localparam logic [3:0] OP_REMU  = 4'd5;
    localparam logic [3:0] OP_DIVW  = 4'd6;
    localparam logic [3:0] OP_DIVUW = 4'd7;
    localparam logic [3:0] OP_REMW  = 4'd8;
    localparam logic [3:0] OP_REMUW = 4'd9;

    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_mul_q, is_mul_d;
    logic        is_rem_q, is_rem_d;
    logic        is_w_q, is_w_d;
    logic        neg_q, neg_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] result_q, result_d;

    // Decode of the incoming op
    logic dec_mul, dec_w, dec_signed, dec_rem;

    always_comb begin
        dec_mul    = 1'b0;
        dec_w      = 1'b0;
        dec_signed = 1'b0;
        dec_rem    = 1'b0;
        case (bus.op)
            OP_MUL:   dec_mul = 1'b1;
            OP_MULW: begin
                dec_mul = 1'b1;
                dec_w   = 1'b1;
            end
            OP_DIV:   dec_signed = 1'b1;
            OP_DIVU:  ;
            OP_REM: begin
                dec_signed = 1'b1;
                dec_rem    = 1'b1;
            end
            OP_REMU:  dec_rem = 1'b1;
            OP_DIVW: begin
                dec_w      = 1'b1;
                dec_signed = 1'b1;
            end
            OP_DIVUW: dec_w = 1'b1;
            OP_REMW: begin
                dec_w      = 1'b1;
                dec_signed = 1'b1;
                dec_rem    = 1'b1;
            end
            OP_REMUW: begin
                dec_w   = 1'b1;
                dec_rem = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand preparation: W divides extend the low word, signed divides take magnitudes
    logic [63:0] op1_p, op2_p, abs1, abs2, spec_raw, spec_res;
    logic        s1, s2, div_zero, div_ovf;

    always_comb begin
        if (dec_w && !dec_mul) begin
            op1_p = dec_signed ? sext32(bus.in1[31:0]) : {32'd0, bus.in1[31:0]};
            op2_p = dec_signed ? sext32(bus.in2[31:0]) : {32'd0, bus.in2[31:0]};
        end else begin
            op1_p = bus.in1;
            op2_p = bus.in2;
        end
        s1       = dec_signed & op1_p[63];
        s2       = dec_signed & op2_p[63];
        abs1     = s1 ? 64'd0 - op1_p : op1_p;
        abs2     = s2 ? 64'd0 - op2_p : op2_p;
        div_zero = !dec_mul && (op2_p == 64'd0);
        div_ovf  = dec_signed && !dec_w && (bus.in1 == INT_MIN) && (bus.in2 == '1);
        if (div_zero) begin
            spec_raw = dec_rem ? op1_p : '1;
        end else begin
            spec_raw = dec_rem ? 64'd0 : bus.in1;
        end
        spec_res = dec_w ? sext32(spec_raw[31:0]) : spec_raw;
    end

    // One iteration step for each datapath, plus the final fix-up applied on the last step
    logic [63:0] mul_acc;
    logic [64:0] div_sh;
    logic        div_ge;
    logic [63:0] div_rem, div_quo;
    logic [63:0] fin_raw, fin_sgn, fin_res;

    always_comb begin
        mul_acc = b_q[0] ? acc_q + a_q : acc_q;
        div_sh  = {acc_q, a_q[63]};
        div_ge  = div_sh >= {1'b0, b_q};
        // When div_ge holds the difference is below the divisor, so 64 bits suffice
        div_rem = div_ge ? div_sh[63:0] - b_q : div_sh[63:0];
        div_quo = {a_q[62:0], div_ge};
        if (is_mul_q) begin
            fin_raw = mul_acc;
        end else begin
            fin_raw = is_rem_q ? div_rem : div_quo;
        end
        fin_sgn = neg_q ? 64'd0 - fin_raw : fin_raw;
        fin_res = is_w_q ? sext32(fin_sgn[31:0]) : fin_sgn;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        is_rem_d = is_rem_q;
        is_w_d   = is_w_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    is_mul_d = dec_mul;
                    is_rem_d = dec_rem;
                    is_w_d   = dec_w;
                    neg_d    = dec_rem ? s1 : (s1 ^ s2);
                    if (div_zero || div_ovf) begin
                        result_d = spec_res;
                        state_d  = StDone;
                    end else begin
                        a_d     = dec_mul ? bus.in1 : abs1;
                        b_d     = dec_mul ? bus.in2 : abs2;
                        acc_d   = 64'd0;
                        cnt_d   = 6'd0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 6'd1;
                if (is_mul_q) begin
                    acc_d = mul_acc;
                    a_d   = {a_q[62:0], 1'b0};
                    b_d   = {1'b0, b_q[63:1]};
                end else begin
                    acc_d = div_rem;
                    a_d   = div_quo;
                end
                if (cnt_q == 6'd63) begin
                    result_d = fin_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over any accept or completion in the same cycle
        if (bus.flush) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            is_w_q   <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            acc_q    <= 64'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            is_rem_q <= is_rem_d;
            is_w_q   <= is_w_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed and random checks of muldiv against an independent RV64M reference model.
module tb_muldiv;
    localparam logic [3:0] OP_MUL   = 4'd0;
    localparam logic [3:0] OP_MULW  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_REM   = 4'd4;
    localparam logic [3:0] OP_REMU  = 4'd5;
    localparam logic [3:0] OP_DIVW  = 4'd6;
    localparam logic [3:0] OP_DIVUW = 4'd7;
    localparam logic [3:0] OP_REMW  = 4'd8;
    localparam logic [3:0] OP_REMUW = 4'd9;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    logic clk;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] exp_q[$];

    muldiv_if bus ();

    muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] r, t, wa, wb;
        t  = a * b;
        wa = {32'd0, a[31:0]};
        wb = {32'd0, b[31:0]};
        sa = a;
        sb = b;
        r  = '0;
        case (o)
            OP_MUL:  r = t;
            OP_MULW: r = sx(t[31:0]);
            OP_DIV:  r = (b == 0) ? '1 : ((a == INT_MIN && b == '1) ? a : sa / sb);
            OP_DIVU: r = (b == 0) ? '1 : a / b;
            OP_REM:  r = (b == 0) ? a : ((a == INT_MIN && b == '1) ? 64'd0 : sa % sb);
            OP_REMU: r = (b == 0) ? a : a % b;
            OP_DIVW: begin
                sa = sx(a[31:0]);
                sb = sx(b[31:0]);
                if (sb == 0) r = '1;
                else begin
                    t = sa / sb;
                    r = sx(t[31:0]);
                end
            end
            OP_DIVUW: begin
                if (wb == 0) r = '1;
                else begin
                    t = wa / wb;
                    r = sx(t[31:0]);
                end
            end
            OP_REMW: begin
                sa = sx(a[31:0]);
                sb = sx(b[31:0]);
                if (sb == 0) r = sa;
                else begin
                    t = sa % sb;
                    r = sx(t[31:0]);
                end
            end
            OP_REMUW: begin
                if (wb == 0) r = sx(a[31:0]);
                else begin
                    t = wa % wb;
                    r = sx(t[31:0]);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int lat_model(input logic [3:0] o, input logic [63:0] a,
                                     input logic [63:0] b);
        if (o == OP_MUL || o == OP_MULW) return 65;
        if (o >= OP_DIVW) return (b[31:0] == 32'd0) ? 1 : 65;
        if (b == 64'd0) return 1;
        if ((o == OP_DIV || o == OP_REM) && a == INT_MIN && b == '1) return 1;
        return 65;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op, push its expected result, then wait for and consume the result
    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] e, input int lat_exp, input int hold,
                          input string tag);
        int lat;
        logic [63:0] exp;
        @(negedge clk);
        check({tag, ".in_ready_before"}, 64'(bus.in_ready), 64'd1);
        bus.op       = o;
        bus.in1      = a;
        bus.in2      = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(lat_exp));
        for (int i = 0; i < hold; i++) begin
            check({tag, ".hold_result"}, bus.result, exp_q[0]);
            check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        check({tag, ".result"}, bus.result, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".valid_after"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [3:0] o;
        logic [63:0] a, b;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_MUL;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.result", bus.result, 64'd0);

        run_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0, "mul");
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, "div");
        run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "rem");
        run_op(OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "divu_zero");
        run_op(OP_REMW, 64'h1_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, 0, "remw_zero");
        run_op(OP_DIV, INT_MIN, '1, INT_MIN, 1, 0, "div_ovf");
        run_op(OP_REM, INT_MIN, '1, 64'd0, 1, 0, "rem_ovf");
        run_op(OP_MULW, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0, "mulw");
        run_op(OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 65, 10,
               "divw_ovf_bp");
        run_op(OP_REMU, 64'd1000, 64'd7, 64'd6, 65, 0, "remu");

        for (int i = 0; i < 12; i++) begin
            o = 4'($urandom_range(0, 9));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 == 0) b = b & 64'hFF;
            if (i == 5) b = 64'd0;
            run_op(o, a, b, model(o, a, b), lat_model(o, a, b), 0, "rand");
        end

        // Flush at counter 30 of a multiply
        @(negedge clk);
        bus.op       = OP_MUL;
        bus.in1      = 64'd3;
        bus.in2      = 64'd5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy.in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_busy.out_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_busy.no_valid_later", 64'(seen), 64'd0);

        // Flush coincident with an accept of a single-cycle op
        bus.op       = OP_DIVU;
        bus.in1      = 64'd5;
        bus.in2      = 64'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_accept.out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_accept.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("flush_accept.out_valid_later", 64'(bus.out_valid), 64'd0);

        // Reset while holding a result
        bus.op       = OP_DIVU;
        bus.in1      = 64'd9;
        bus.in2      = 64'd0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("reset_done.out_valid_before", 64'(bus.out_valid), 64'd1);
        check("reset_done.result_before", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_done.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_done.in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_done.result", bus.result, 64'd0);

        run_op(OP_DIVU, 64'd100, 64'd9, 64'd11, 65, 0, "after_reset");
        check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative 64-bit RV64M multiply/divide unit in the execute stage. It is the consumer of the operand pair (`alu_in1`, `alu_in2`) when the decoded op is an M-extension op. It holds the pipeline through a valid/ready handshake while it computes, one bit per cycle, and returns one 64-bit result.

## Interface
- No parameters; operand width fixed at 64 (u64 from common).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op valid this cycle.
- `in_ready`  out  1  unit idle and able to accept; accept = `in_valid & in_ready`.
- `op`  in  op_t  one of OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW; sampled on accept.
- `in1`  in  64  dividend / multiplicand, from `alu_in1`.
- `in2`  in  64  divisor / multiplier, from `alu_in2`.
- `flush`  in  1  abort any operation and drop any held result.
- `out_valid`  out  1  `result` valid; held until consumed.
- `out_ready`  in  1  consumer takes result; handshake completes on `out_valid & out_ready`.
- `result`  out  64  final value; only meaningful while `out_valid`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On accept, latch the op and the prepared operands:
  - W ops: DIVW/REMW sign-extend low 32 bits of each operand; DIVUW/REMUW zero-extend them; MULW uses the low 32 bits as-is.
  - Signed divides store the absolute values plus sign flags. Quotient sign = sign(in1) XOR sign(in2). Remainder sign = sign(in1).
- Special cases go IDLE->DONE directly, with no BUSY cycles:
  - Divisor == 0: quotient = all ones; remainder = prepared dividend.
  - DIV/REM with in1 = 0x8000_0000_0000_0000 and in2 = all ones: quotient = in1; remainder = 0.
- All other accepts go IDLE->BUSY with counter = 0.
- BUSY, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator. Only the low 64 bits of the product are kept.
- BUSY, divide: unsigned restoring division, one quotient bit per cycle, MSB first. Uses a 64-bit partial remainder plus a 1-bit carry compare.
- BUSY ends after cycle 63 (counter wraps 63->0): apply sign fix-up and W post-processing, then go to DONE.
- W post-processing: result = sign-extension of bit 31 of the 64-bit result. This also holds for DIVUW/REMUW.
- DIVW overflow (-2^31 / -1) needs no special path: the 64-bit quotient 2^31 truncates to 0x8000_0000 and sign-extends to 0xFFFF_FFFF_8000_0000.
- DONE: `out_valid`=1 and `result` stays stable. On `out_ready`, go to IDLE. The unit does not accept a new op in the same cycle.
- `flush`: from any state, go to IDLE next cycle and clear `out_valid`. `flush` beats a simultaneous accept: the op is not accepted, even though `in_ready` was 1.
- `reset`: same effect as `flush`. Mid-operation counter and data are discarded.

## Timing
- Reset values: state = IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter = 0.
- `in_ready` = (state == IDLE). It is combinational from state only, never from `in_valid`.
- `out_valid` = (state == DONE), registered.
- Normal op accepted at edge T:
  - BUSY during cycles T+1..T+64.
  - `out_valid` high from cycle T+65.
- Special case accepted at edge T: `out_valid` high from cycle T+1.
- Earliest next accept is the cycle after the result handshake, so back-to-back normal ops take at least 66 cycles each.
- `result` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- MUL: in1=7, in2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB (-21); `out_valid` rises exactly 65 cycles after accept.
- DIV/REM signs: in1=-7, in2=2 -> DIV gives -3 (0xFFFF_FFFF_FFFF_FFFD); REM gives -1 (0xFFFF_FFFF_FFFF_FFFF).
- Divide by zero: DIVU in1=5, in2=0 -> all ones after 1 cycle. REMW in1=0x1_8000_0001, in2=0 -> 0xFFFF_FFFF_8000_0001.
- Overflow:
  - DIV in1=0x8000_0000_0000_0000, in2=-1 -> 0x8000_0000_0000_0000, REM -> 0, both in 1 cycle.
  - DIVW in1=0x8000_0000, in2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `result` and `out_valid` stable, `in_ready`=0; then raise `out_ready` -> IDLE next cycle.
- Flush/reset mid-BUSY:
  - Assert `flush` at counter=30 -> IDLE next cycle, no `out_valid`.
  - `flush` coincident with `in_valid` in IDLE -> nothing accepted.
  - `reset` in DONE -> `out_valid`=0 next cycle.
